// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the writeback/register-file slice.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_core.sv
// Plain 2R1W register array with synchronous clear.
// Index-0 masking and bypass live in wb_regfile.
module regfile_core #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = mem[ra1];
   assign rd2 = mem[ra2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback result select, register file commit and ID read ports.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ReadData_WB,
   input  logic [DATA_W-1:0] ALUResult_WB,
   input  logic [ADDR_W-1:0] writereg_WB,
   input  logic              RegWrite_WB,
   input  logic              MemtoReg_WB,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] Result_WB,
   output logic [CNT_W-1:0]  wb_count
);

   import mips_pkg::REG_ZERO;

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic              commit;
   logic [DATA_W-1:0] core_rd1;
   logic [DATA_W-1:0] core_rd2;

   assign Result_WB = MemtoReg_WB ? ReadData_WB : ALUResult_WB;

   // Reset wins over a write presented in the same cycle.
   assign commit = !rst && RegWrite_WB && (writereg_WB != ZERO_IDX);

   regfile_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk (clk),
      .rst (rst),
      .we  (commit),
      .wa  (writereg_WB),
      .wd  (Result_WB),
      .ra1 (ra1),
      .ra2 (ra2),
      .rd1 (core_rd1),
      .rd2 (core_rd2)
   );

   always_comb begin
      rd1 = core_rd1;
      if (rst || ra1 == ZERO_IDX) begin
         rd1 = '0;
      end
`ifdef WB_BYPASS_EN
      else if (commit && writereg_WB == ra1) begin
         rd1 = Result_WB;
      end
`endif
   end

   always_comb begin
      rd2 = core_rd2;
      if (rst || ra2 == ZERO_IDX) begin
         rd2 = '0;
      end
`ifdef WB_BYPASS_EN
      else if (commit && writereg_WB == ra2) begin
         rd2 = Result_WB;
      end
`endif
   end

   // Saturating commit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count <= '0;
      end else if (commit && wb_count != '1) begin
         wb_count <= wb_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table plus random
// traffic against an array-based reference model.
module tb_wb_regfile;

   import mips_pkg::*;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   word_t       ReadData_WB;
   word_t       ALUResult_WB;
   reg_idx_t    writereg_WB;
   logic        RegWrite_WB;
   logic        MemtoReg_WB;
   reg_idx_t    ra1;
   reg_idx_t    ra2;
   word_t       rd1;
   word_t       rd2;
   word_t       Result_WB;
   logic [31:0] wb_count;
   word_t       rd1_s;
   word_t       rd2_s;
   word_t       res_s;
   logic [1:0]  cnt_s;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .ReadData_WB  (ReadData_WB),
      .ALUResult_WB (ALUResult_WB),
      .writereg_WB  (writereg_WB),
      .RegWrite_WB  (RegWrite_WB),
      .MemtoReg_WB  (MemtoReg_WB),
      .ra1          (ra1),
      .ra2          (ra2),
      .rd1          (rd1),
      .rd2          (rd2),
      .Result_WB    (Result_WB),
      .wb_count     (wb_count)
   );

   wb_regfile #(.CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .ReadData_WB  (ReadData_WB),
      .ALUResult_WB (ALUResult_WB),
      .writereg_WB  (writereg_WB),
      .RegWrite_WB  (RegWrite_WB),
      .MemtoReg_WB  (MemtoReg_WB),
      .ra1          (ra1),
      .ra2          (ra2),
      .rd1          (rd1_s),
      .rd2          (rd2_s),
      .Result_WB    (res_s),
      .wb_count     (cnt_s)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: architectural register contents and commit count.
   word_t       mdl [32];
   int unsigned mcnt;

   function automatic word_t m_res();
      return MemtoReg_WB ? ReadData_WB : ALUResult_WB;
   endfunction

   function automatic bit m_commit();
      return !rst && RegWrite_WB && writereg_WB != 5'd0;
   endfunction

   function automatic word_t m_rd(input reg_idx_t a);
      if (rst || a == 5'd0) return '0;
      if (BYP && m_commit() && writereg_WB == a) return m_res();
      return mdl[a];
   endfunction

   task automatic clock_commit();
      @(posedge clk);
      if (rst) begin
         foreach (mdl[i]) mdl[i] = '0;
         mcnt = 0;
      end else if (m_commit()) begin
         mdl[writereg_WB] = m_res();
         mcnt++;
      end
      #1;
   endtask

   task automatic drive(input bit r, input bit rw, input bit mtr,
                        input word_t rdat, input word_t alu,
                        input reg_idx_t wr, input reg_idx_t a1,
                        input reg_idx_t a2);
      rst          = r;
      RegWrite_WB  = rw;
      MemtoReg_WB  = mtr;
      ReadData_WB  = rdat;
      ALUResult_WB = alu;
      writereg_WB  = wr;
      ra1          = a1;
      ra2          = a2;
   endtask

   typedef struct {
      bit       r;
      bit       rw;
      bit       mtr;
      word_t    rdat;
      word_t    alu;
      reg_idx_t wr;
      reg_idx_t a1;
      reg_idx_t a2;
      word_t    e_rd1;
      word_t    e_rd2;
      word_t    e_res;
      int       e_cnt;
   } vec_t;

   vec_t vt [12];

   initial begin
      vt[0]  = '{1, 0, 0, 0, 0, 0, 5, 31, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 0, 0, 32'hDEADBEEF, 5, 5, 0,
                 BYP ? 32'hDEADBEEF : 32'h0, 0, 32'hDEADBEEF, 0};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 5, 5,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 1};
      vt[3]  = '{0, 1, 1, 32'h12345678, 32'hFFFFFFFF, 31, 31, 5,
                 BYP ? 32'h12345678 : 32'h0, 32'hDEADBEEF,
                 32'h12345678, 1};
      vt[4]  = '{0, 0, 0, 0, 0, 0, 31, 0, 32'h12345678, 0, 0, 2};
      vt[5]  = '{0, 1, 0, 0, 32'hA5A5A5A5, 0, 0, 0,
                 0, 0, 32'hA5A5A5A5, 2};
      vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
      vt[7]  = '{0, 1, 0, 0, 1, 7, 3, 3, 0, 0, 1, 2};
      vt[8]  = '{0, 1, 0, 0, 2, 7, 7, 7,
                 BYP ? 32'd2 : 32'd1, BYP ? 32'd2 : 32'd1, 2, 3};
      vt[9]  = '{0, 0, 0, 0, 0, 0, 7, 5, 2, 32'hDEADBEEF, 0, 4};
      vt[10] = '{1, 1, 0, 0, 32'h55, 3, 3, 7, 0, 0, 32'h55, 4};
      vt[11] = '{0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0};

      foreach (mdl[i]) mdl[i] = '0;
      mcnt = 0;

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      clock_commit();
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 32; i++) begin
         ra1 = reg_idx_t'(i);
         ra2 = reg_idx_t'(31 - i);
         #1;
         check($sformatf("reset_rd1[%0d]", i), rd1, 0);
         check($sformatf("reset_rd2[%0d]", 31 - i), rd2, 0);
      end
      check("reset_cnt", wb_count, 0);
      check("reset_cnt_sat", {30'd0, cnt_s}, 0);

      for (int i = 0; i < 12; i++) begin
         drive(vt[i].r, vt[i].rw, vt[i].mtr, vt[i].rdat, vt[i].alu,
               vt[i].wr, vt[i].a1, vt[i].a2);
         @(negedge clk);
         check($sformatf("vec%0d_rd1", i), rd1, vt[i].e_rd1);
         check($sformatf("vec%0d_rd2", i), rd2, vt[i].e_rd2);
         check($sformatf("vec%0d_res", i), Result_WB, vt[i].e_res);
         check($sformatf("vec%0d_cnt", i), wb_count, vt[i].e_cnt);
         clock_commit();
      end

      for (int i = 1; i <= 5; i++) begin
         drive(0, 1, 0, 0, word_t'(i * 16), reg_idx_t'(i), 0, 0);
         clock_commit();
      end
      drive(0, 0, 0, 0, 0, 0, 4, 5);
      #1;
      check("sat_cnt", {30'd0, cnt_s}, 3);
      check("unsat_cnt", wb_count, 5);
      check("sat_rd1", rd1, 32'h40);
      check("sat_rd2", rd2, 32'h50);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(31) == 0), $urandom_range(1),
               $urandom_range(1), $urandom, $urandom,
               reg_idx_t'($urandom_range(31)),
               reg_idx_t'($urandom_range(31)),
               reg_idx_t'($urandom_range(31)));
         if ($urandom_range(3) == 0) ra1 = writereg_WB;
         if ($urandom_range(7) == 0) ra2 = ra1;
         @(negedge clk);
         check("rnd_rd1", rd1, m_rd(ra1));
         check("rnd_rd2", rd2, m_rd(ra2));
         check("rnd_res", Result_WB, m_res());
         check("rnd_cnt", wb_count, mcnt);
         check("rnd_cnt_sat", {30'd0, cnt_s}, (mcnt > 3) ? 3 : mcnt);
         clock_commit();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
